// File: rtl/env_step_unit.sv
// Grid-world environment step: turns (current_location, action) into the next cell, a reward
// and episode flags, with a three-state IDLE/CALC/OUT handshake and a per-episode step counter.
module env_step_unit #(
    parameter int unsigned                   DATA_LENGTH   = 6,
    parameter int unsigned                   GRID_WIDTH    = 8,
    parameter int unsigned                   GRID_HEIGHT   = 8,
    parameter int unsigned                   GOAL_LOCATION = 63,
    parameter logic [2**DATA_LENGTH-1:0]     WALL_MAP      = '0,
    parameter int unsigned                   MAX_STEPS     = 255,
    parameter int unsigned                   STEP_WIDTH    = 8,
    parameter int unsigned                   REWARD_WIDTH  = 8,
    parameter int                            GOAL_REWARD   = 100,
    parameter int                            STEP_REWARD   = -1,
    parameter int                            WALL_REWARD   = -5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_LENGTH-1:0]         current_location,
    input  logic [1:0]                     action,
    input  logic                           episode_start,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_LENGTH-1:0]         next_location,
    output logic signed [REWARD_WIDTH-1:0] reward,
    output logic                           done,
    output logic                           truncated,
    output logic [STEP_WIDTH-1:0]          step_count
);

    localparam int unsigned NUM_CELLS = GRID_WIDTH * GRID_HEIGHT;

    localparam logic [DATA_LENGTH-1:0]   GW       = DATA_LENGTH'(GRID_WIDTH);
    localparam logic [DATA_LENGTH-1:0]   COL_LAST = DATA_LENGTH'(GRID_WIDTH - 1);
    localparam logic [DATA_LENGTH-1:0]   ROW_LAST = DATA_LENGTH'(GRID_HEIGHT - 1);
    localparam logic [DATA_LENGTH-1:0]   GOAL     = DATA_LENGTH'(GOAL_LOCATION);
    localparam logic [DATA_LENGTH:0]     CELLS_W  = (DATA_LENGTH + 1)'(NUM_CELLS);
    localparam logic [STEP_WIDTH:0]      MAX_W    = (STEP_WIDTH + 1)'(MAX_STEPS);

    localparam logic signed [REWARD_WIDTH-1:0] R_GOAL = REWARD_WIDTH'(GOAL_REWARD);
    localparam logic signed [REWARD_WIDTH-1:0] R_STEP = REWARD_WIDTH'(STEP_REWARD);
    localparam logic signed [REWARD_WIDTH-1:0] R_WALL = REWARD_WIDTH'(WALL_REWARD);

    typedef enum logic [1:0] {StIdle, StCalc, StOut} state_e;

    state_e                          state_q, state_d;
    logic [DATA_LENGTH-1:0]          loc_q, loc_d;
    logic [1:0]                      act_q, act_d;
    logic [DATA_LENGTH-1:0]          next_loc_q, next_loc_d;
    logic signed [REWARD_WIDTH-1:0]  reward_q, reward_d;
    logic                            done_q, done_d;
    logic                            trunc_q, trunc_d;
    logic [STEP_WIDTH-1:0]           step_q, step_d;
    logic                            in_ready_q, in_ready_d;
    logic                            out_valid_q, out_valid_d;

    logic [DATA_LENGTH-1:0] row, col, target, move_next;
    logic                   blocked;

    // Move evaluation on the captured request; divisions are by constants.
    always_comb begin
        row     = loc_q / GW;
        col     = loc_q % GW;
        target  = loc_q;
        blocked = 1'b0;
        unique case (act_q)
            2'd0: begin blocked = (row == '0);      target = loc_q - GW;   end
            2'd1: begin blocked = (col == COL_LAST); target = loc_q + 1'b1; end
            2'd2: begin blocked = (row == ROW_LAST); target = loc_q + GW;   end
            2'd3: begin blocked = (col == '0);      target = loc_q - 1'b1; end
        endcase
        if (WALL_MAP[target]) blocked = 1'b1;
        if ({1'b0, loc_q} >= CELLS_W) blocked = 1'b1;
        move_next = blocked ? loc_q : target;
    end

    always_comb begin
        state_d     = state_q;
        loc_d       = loc_q;
        act_d       = act_q;
        next_loc_d  = next_loc_q;
        reward_d    = reward_q;
        done_d      = done_q;
        trunc_d     = trunc_q;
        step_d      = step_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    loc_d      = current_location;
                    act_d      = action;
                    in_ready_d = 1'b0;
                    state_d    = StCalc;
                end
            end
            StCalc: begin
                next_loc_d  = move_next;
                if (blocked)             reward_d = R_WALL;
                else if (target == GOAL) reward_d = R_GOAL;
                else                     reward_d = R_STEP;
                done_d      = (move_next == GOAL);
                trunc_d     = (move_next != GOAL) && (({1'b0, step_q} + 1'b1) == MAX_W);
                out_valid_d = 1'b1;
                state_d     = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    step_d      = (done_q || trunc_q) ? '0 : step_q + 1'b1;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = StIdle;
            end
        endcase

        // A new episode always wins over the acceptance update.
        if (episode_start) step_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            loc_q       <= '0;
            act_q       <= '0;
            next_loc_q  <= '0;
            reward_q    <= '0;
            done_q      <= 1'b0;
            trunc_q     <= 1'b0;
            step_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            loc_q       <= loc_d;
            act_q       <= act_d;
            next_loc_q  <= next_loc_d;
            reward_q    <= reward_d;
            done_q      <= done_d;
            trunc_q     <= trunc_d;
            step_q      <= step_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign next_location = next_loc_q;
    assign reward        = reward_q;
    assign done          = done_q;
    assign truncated     = trunc_q;
    assign step_count    = step_q;

endmodule

// File: tb/tb_env_step_unit.sv
// Scoreboard bench for env_step_unit on an 8x8 grid with 7-bit locations, a wall at cell 10
// and a four-step budget so truncation and invalid sources are reachable.
module tb_env_step_unit;

    localparam int DL        = 7;
    localparam int GW        = 8;
    localparam int GH        = 8;
    localparam int GOAL      = 63;
    localparam int MAX_STEPS = 4;
    localparam logic [127:0] TB_WALL = 128'h400;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  in_valid;
    logic                  in_ready;
    logic [DL-1:0]         current_location;
    logic [1:0]            action;
    logic                  episode_start;
    logic                  out_valid;
    logic                  out_ready;
    logic [DL-1:0]         next_location;
    logic signed [7:0]     reward;
    logic                  done;
    logic                  truncated;
    logic [7:0]            step_count;

    always #5 clk = ~clk;

    env_step_unit #(
        .DATA_LENGTH   (DL),
        .GRID_WIDTH    (GW),
        .GRID_HEIGHT   (GH),
        .GOAL_LOCATION (GOAL),
        .WALL_MAP      (TB_WALL),
        .MAX_STEPS     (MAX_STEPS),
        .STEP_WIDTH    (8),
        .REWARD_WIDTH  (8),
        .GOAL_REWARD   (100),
        .STEP_REWARD   (-1),
        .WALL_REWARD   (-5)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .current_location (current_location),
        .action           (action),
        .episode_start    (episode_start),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .next_location    (next_location),
        .reward           (reward),
        .done             (done),
        .truncated        (truncated),
        .step_count       (step_count)
    );

    typedef struct {
        int nl;
        int rw;
        int dn;
        int tr;
    } exp_t;

    exp_t sb_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   model_cnt = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference move using signed row/col arithmetic and an explicit bounds test.
    task automatic ref_move(input int loc, input int act, output int nl, output int rw);
        int r, c, nr, nc, tgt;
        r  = loc / GW;
        c  = loc % GW;
        nr = r + ((act == 2) ? 1 : 0) - ((act == 0) ? 1 : 0);
        nc = c + ((act == 1) ? 1 : 0) - ((act == 3) ? 1 : 0);
        tgt = nr * GW + nc;
        if (loc >= GW * GH || nr < 0 || nr >= GH || nc < 0 || nc >= GW || TB_WALL[tgt]) begin
            nl = loc;
            rw = -5;
        end else begin
            nl = tgt;
            rw = (tgt == GOAL) ? 100 : -1;
        end
    endtask

    task automatic do_step(input int loc, input int act, input int hold, input bit ep);
        exp_t e;
        int   nl, rw;
        bit   got;
        ref_move(loc, act, nl, rw);
        e.nl = nl;
        e.rw = rw;
        e.dn = (nl == GOAL) ? 1 : 0;
        e.tr = (e.dn == 0 && model_cnt + 1 == MAX_STEPS) ? 1 : 0;
        sb_q.push_back(e);

        current_location = DL'(loc);
        action           = 2'(act);
        in_valid         = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_val("calc_in_ready", int'(in_ready), 0);
        check_val("calc_out_valid", int'(out_valid), 0);

        @(posedge clk); #1;
        check_val("latency_out_valid", int'(out_valid), 1);
        got = out_valid;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            got = out_valid;
        end
        if (!got) begin
            void'(sb_q.pop_front());
            return;
        end

        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_val("hold_out_valid", int'(out_valid), 1);
            check_val("hold_in_ready", int'(in_ready), 0);
            check_val("hold_next", int'(next_location), sb_q[0].nl);
            check_val("hold_reward", int'(reward), sb_q[0].rw);
        end

        e = sb_q.pop_front();
        check_val("next_location", int'(next_location), e.nl);
        check_val("reward", int'(reward), e.rw);
        check_val("done", int'(done), e.dn);
        check_val("truncated", int'(truncated), e.tr);

        out_ready     = 1'b1;
        episode_start = ep;
        @(posedge clk); #1;
        out_ready     = 1'b0;
        episode_start = 1'b0;
        model_cnt = (ep || e.dn != 0 || e.tr != 0) ? 0 : model_cnt + 1;
        check_val("step_count", int'(step_count), model_cnt);
        check_val("post_out_valid", int'(out_valid), 0);
        check_val("post_in_ready", int'(in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset            = 1'b0;
        in_valid         = 1'b0;
        current_location = '0;
        action           = '0;
        episode_start    = 1'b0;
        out_ready        = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        check_val("rst_out_valid", int'(out_valid), 0);
        check_val("rst_next", int'(next_location), 0);
        check_val("rst_reward", int'(reward), 0);
        check_val("rst_step_count", int'(step_count), 0);
        check_val("rst_in_ready", int'(in_ready), 1);
        check_val("rst_done", int'(done), 0);

        do_step(17, 1, 0, 1'b0);   // legal step
        do_step(9, 1, 3, 1'b0);    // wall at 10, stalled consumer
        do_step(7, 1, 0, 1'b0);    // right edge
        do_step(0, 0, 0, 1'b0);    // top edge, budget runs out
        do_step(56, 3, 1, 1'b0);   // left edge
        do_step(64, 0, 0, 1'b0);   // source outside the grid
        do_step(62, 1, 0, 1'b0);   // enter goal
        do_step(9, 3, 0, 1'b0);
        do_step(8, 2, 0, 1'b1);    // new episode at acceptance
        do_step(55, 2, 0, 1'b0);   // goal from above
        do_step(63, 1, 0, 1'b0);   // blocked while on goal still flags done
        do_step(16, 1, 0, 1'b0);

        episode_start = 1'b1;
        @(posedge clk); #1;
        episode_start = 1'b0;
        model_cnt = 0;
        check_val("idle_episode_clear", int'(step_count), model_cnt);

        for (int n = 0; n < 30; n++) begin
            do_step(int'($urandom_range(0, 71)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0));
        end

        current_location = DL'(17);
        action           = 2'd1;
        in_valid         = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset    = 1'b0;
        @(posedge clk); #1;
        reset     = 1'b1;
        out_ready = 1'b1;
        model_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_val("calc_reset_out_valid", int'(out_valid), 0);
            check_val("calc_reset_in_ready", int'(in_ready), 1);
        end
        check_val("calc_reset_step_count", int'(step_count), model_cnt);
        out_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
